// File: rtl/viterbi_pkg.sv
// Shared Viterbi helpers: log2 sizing, normalization mode codes and
// path-metric vector pack/unpack functions.
package viterbi_pkg;

  localparam int unsigned NORM_ALWAYS = 0;
  localparam int unsigned NORM_THRESH = 1;

  localparam int unsigned PM_W_MAX   = 32;
  localparam int unsigned STATES_MAX = 64;
  localparam int unsigned VEC_MAX    = STATES_MAX * PM_W_MAX;

  typedef logic [VEC_MAX-1:0]  pm_vec_t;
  typedef logic [PM_W_MAX-1:0] pm_word_t;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = i + 1;
    end
    return r;
  endfunction

  // Extract metric idx of width w from a packed vector.
  function automatic pm_word_t pm_get(input pm_vec_t vec, input int unsigned idx,
                                      input int unsigned w);
    pm_vec_t mask;
    mask = (pm_vec_t'(1) << w) - pm_vec_t'(1);
    return pm_word_t'((vec >> (idx * w)) & mask);
  endfunction

  // Insert metric idx of width w into a packed vector.
  function automatic pm_vec_t pm_set(input pm_vec_t vec, input int unsigned idx,
                                     input int unsigned w, input pm_word_t val);
    pm_vec_t mask;
    mask = ((pm_vec_t'(1) << w) - pm_vec_t'(1)) << (idx * w);
    return (vec & ~mask) | ((pm_vec_t'(val) << (idx * w)) & mask);
  endfunction

endpackage

// File: rtl/pm_min2.sv
// Registered two-input minimum cell; left input wins ties so the lowest
// index survives among equal metrics.
module pm_min2 #(
  parameter int unsigned PM_W  = 5,
  parameter int unsigned IDX_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [PM_W-1:0]  a_val,
  input  logic [IDX_W-1:0] a_idx,
  input  logic [PM_W-1:0]  b_val,
  input  logic [IDX_W-1:0] b_idx,
  output logic [PM_W-1:0]  min_val,
  output logic [IDX_W-1:0] min_idx
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      min_val <= '0;
      min_idx <= '0;
    end else if (en) begin
      if (b_val < a_val) begin
        min_val <= b_val;
        min_idx <= b_idx;
      end else begin
        min_val <= a_val;
        min_idx <= a_idx;
      end
    end
  end

endmodule

// File: rtl/pm_normalize_pipe.sv
// Pipelined path-metric normalizer: registered min tree of IDX_W levels
// followed by one subtraction stage, with a single global advance.
module pm_normalize_pipe
  import viterbi_pkg::*;
#(
  parameter int unsigned NUM_STATES = 4,
  parameter int unsigned PM_W       = 5,
  parameter int unsigned NORM_MODE  = NORM_ALWAYS,
  parameter int unsigned THRESH     = 16,
  localparam int unsigned IDX_W     = clog2(NUM_STATES)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [NUM_STATES*PM_W-1:0] pm_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [NUM_STATES*PM_W-1:0] pm_out,
  output logic [IDX_W-1:0]           min_idx,
  output logic [PM_W-1:0]            min_val,
  output logic                       normalized,
  output logic                       sat_flag,
  input  logic                       sat_clr
);

  localparam int unsigned VEC_W = NUM_STATES * PM_W;
  localparam pm_word_t    PM_MAX = pm_word_t'((64'd1 << PM_W) - 64'd1);

  if (NUM_STATES < 2 || NUM_STATES > STATES_MAX ||
      (NUM_STATES & (NUM_STATES - 1)) != 0) begin : g_bad_states
    $error("pm_normalize_pipe: NUM_STATES must be a power of 2 in 2..64");
  end
  if (PM_W < 1 || PM_W > PM_W_MAX) begin : g_bad_width
    $error("pm_normalize_pipe: PM_W must be in 1..32");
  end
  if (64'(THRESH) >= (64'd1 << PM_W)) begin : g_bad_thresh
    $error("pm_normalize_pipe: THRESH must be below 2**PM_W");
  end

  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Tree candidates of levels 1..IDX_W packed back to back; root is last.
  logic [PM_W-1:0]  cand_val [NUM_STATES-1];
  logic [IDX_W-1:0] cand_idx [NUM_STATES-1];

  for (genvar k = 1; k <= IDX_W; k++) begin : g_lvl
    localparam int unsigned CNT = NUM_STATES >> k;
    localparam int unsigned OFF = NUM_STATES - 2 * CNT;
    for (genvar j = 0; j < CNT; j++) begin : g_cell
      logic [PM_W-1:0]  a_val, b_val;
      logic [IDX_W-1:0] a_idx, b_idx;
      if (k == 1) begin : g_leaf
        assign a_val = PM_W'(pm_get(pm_vec_t'(pm_in), 2 * j, PM_W));
        assign b_val = PM_W'(pm_get(pm_vec_t'(pm_in), 2 * j + 1, PM_W));
        assign a_idx = IDX_W'(2 * j);
        assign b_idx = IDX_W'(2 * j + 1);
      end else begin : g_node
        localparam int unsigned POFF = NUM_STATES - 4 * CNT;
        assign a_val = cand_val[POFF + 2 * j];
        assign b_val = cand_val[POFF + 2 * j + 1];
        assign a_idx = cand_idx[POFF + 2 * j];
        assign b_idx = cand_idx[POFF + 2 * j + 1];
      end
      pm_min2 #(.PM_W(PM_W), .IDX_W(IDX_W)) u_min2 (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (adv),
        .a_val   (a_val),
        .a_idx   (a_idx),
        .b_val   (b_val),
        .b_idx   (b_idx),
        .min_val (cand_val[OFF + j]),
        .min_idx (cand_idx[OFF + j])
      );
    end
  end

  // Valid bit and full vector travel alongside each tree level.
  logic             stg_vld [IDX_W];
  logic [VEC_W-1:0] stg_vec [IDX_W];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < IDX_W; k++) begin
        stg_vld[k] <= 1'b0;
        stg_vec[k] <= '0;
      end
    end else if (adv) begin
      stg_vld[0] <= in_valid;
      stg_vec[0] <= pm_in;
      for (int unsigned k = 1; k < IDX_W; k++) begin
        stg_vld[k] <= stg_vld[k-1];
        stg_vec[k] <= stg_vec[k-1];
      end
    end
  end

  logic [PM_W-1:0]  root_val;
  logic [IDX_W-1:0] root_idx;
  logic             apply_c;
  logic [VEC_W-1:0] norm_vec_c;
  pm_vec_t          norm_acc;
  pm_word_t         norm_word;
  logic             sat_hit_c;

  assign root_val = cand_val[NUM_STATES-2];
  assign root_idx = cand_idx[NUM_STATES-2];
  assign apply_c  = (NORM_MODE == NORM_ALWAYS) || (root_val >= PM_W'(THRESH));

  // Subtraction cannot underflow: the root is the minimum of this vector.
  always_comb begin
    norm_acc  = '0;
    norm_word = '0;
    for (int unsigned i = 0; i < NUM_STATES; i++) begin
      norm_word = pm_get(pm_vec_t'(stg_vec[IDX_W-1]), i, PM_W);
      if (apply_c) norm_word = norm_word - pm_word_t'(root_val);
      norm_acc = pm_set(norm_acc, i, PM_W, norm_word);
    end
    norm_vec_c = VEC_W'(norm_acc);
  end

  always_comb begin
    sat_hit_c = 1'b0;
    for (int unsigned i = 0; i < NUM_STATES; i++) begin
      if (pm_get(pm_vec_t'(pm_in), i, PM_W) == PM_MAX) sat_hit_c = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      pm_out     <= '0;
      min_idx    <= '0;
      min_val    <= '0;
      normalized <= 1'b0;
    end else if (adv) begin
      out_valid <= stg_vld[IDX_W-1];
      if (stg_vld[IDX_W-1]) begin
        pm_out     <= norm_vec_c;
        min_idx    <= root_idx;
        min_val    <= root_val;
        normalized <= apply_c;
      end
    end
  end

  // Sticky saturation flag; a new hit beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sat_flag <= 1'b0;
    end else if (in_valid && adv && sat_hit_c) begin
      sat_flag <= 1'b1;
    end else if (sat_clr) begin
      sat_flag <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pm_normalize_pipe.sv
// Bench for pm_normalize_pipe: mode-0 and mode-1 instances on shared stimulus,
// checked against a queue-based reference model plus literal expectations.
module tb_pm_normalize_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [19:0] pm_in;
  logic        out_ready;
  logic        sat_clr;

  logic        in_ready_a, out_valid_a, normalized_a, sat_flag_a;
  logic [19:0] pm_out_a;
  logic [1:0]  min_idx_a;
  logic [4:0]  min_val_a;
  logic        in_ready_b, out_valid_b, normalized_b, sat_flag_b;
  logic [19:0] pm_out_b;
  logic [1:0]  min_idx_b;
  logic [4:0]  min_val_b;

  int checks = 0;
  int errors = 0;

  pm_normalize_pipe #(.NUM_STATES(4), .PM_W(5), .NORM_MODE(0), .THRESH(16)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a), .pm_in(pm_in),
    .out_valid(out_valid_a), .out_ready(out_ready), .pm_out(pm_out_a), .min_idx(min_idx_a),
    .min_val(min_val_a), .normalized(normalized_a), .sat_flag(sat_flag_a), .sat_clr(sat_clr)
  );

  pm_normalize_pipe #(.NUM_STATES(4), .PM_W(5), .NORM_MODE(1), .THRESH(16)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b), .pm_in(pm_in),
    .out_valid(out_valid_b), .out_ready(out_ready), .pm_out(pm_out_b), .min_idx(min_idx_b),
    .min_val(min_val_b), .normalized(normalized_b), .sat_flag(sat_flag_b), .sat_clr(sat_clr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [19:0] pm;
    logic [1:0]  idx;
    logic [4:0]  mv;
    logic        nrm;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;
  logic sat_m;

  function automatic logic [19:0] vec4(input int a0, input int a1, input int a2, input int a3);
    return {5'(a3), 5'(a2), 5'(a1), 5'(a0)};
  endfunction

  // Reference: plain scan for the first minimum, then optional subtraction.
  function automatic exp_t model(input logic [19:0] v, input int mode);
    exp_t r;
    int e[4];
    int m, mi;
    bit apply;
    for (int i = 0; i < 4; i++) e[i] = int'(v[i*5 +: 5]);
    m = e[0];
    mi = 0;
    for (int i = 1; i < 4; i++) if (e[i] < m) begin m = e[i]; mi = i; end
    apply = (mode == 0) || (m >= 16);
    r.pm = vec4(apply ? e[0]-m : e[0], apply ? e[1]-m : e[1],
                apply ? e[2]-m : e[2], apply ? e[3]-m : e[3]);
    r.idx = 2'(mi);
    r.mv  = 5'(m);
    r.nrm = apply;
    return r;
  endfunction

  function automatic bit has_max(input logic [19:0] v);
    for (int i = 0; i < 4; i++) if (v[i*5 +: 5] == 5'd31) return 1'b1;
    return 1'b0;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [19:0] v);
    int n;
    n = 0;
    in_valid = 1'b1;
    pm_in    = v;
    while (!in_ready_a && n < 50) begin step(); n++; end
    chk("send_wait_bound", 32'(n >= 50), 32'd0);
    step();
    in_valid = 1'b0;
  endtask

  // Per-cycle compare against the model queues, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      qa.delete();
      qb.delete();
      sat_m = 1'b0;
    end else begin
      if (out_valid_a) begin
        if (qa.size() == 0) begin
          checks++; errors++;
          $display("FAIL a_spurious out_valid act=1 exp=0 at %0t", $time);
        end else begin
          ea = qa[0];
          chk("a_pm_out", 32'(pm_out_a), 32'(ea.pm));
          chk("a_min_idx", 32'(min_idx_a), 32'(ea.idx));
          chk("a_min_val", 32'(min_val_a), 32'(ea.mv));
          chk("a_normalized", 32'(normalized_a), 32'(ea.nrm));
          if (out_ready) void'(qa.pop_front());
        end
      end
      if (out_valid_b) begin
        if (qb.size() == 0) begin
          checks++; errors++;
          $display("FAIL b_spurious out_valid act=1 exp=0 at %0t", $time);
        end else begin
          eb = qb[0];
          chk("b_pm_out", 32'(pm_out_b), 32'(eb.pm));
          chk("b_min_idx", 32'(min_idx_b), 32'(eb.idx));
          chk("b_min_val", 32'(min_val_b), 32'(eb.mv));
          chk("b_normalized", 32'(normalized_b), 32'(eb.nrm));
          if (out_ready) void'(qb.pop_front());
        end
      end
      chk("a_in_ready", 32'(in_ready_a), 32'(!out_valid_a || out_ready));
      chk("b_in_ready", 32'(in_ready_b), 32'(!out_valid_b || out_ready));
      chk("a_sat_flag", 32'(sat_flag_a), 32'(sat_m));
      chk("b_sat_flag", 32'(sat_flag_b), 32'(sat_m));
      if (in_valid && in_ready_a) begin
        qa.push_back(model(pm_in, 0));
        qb.push_back(model(pm_in, 1));
        if (has_max(pm_in)) sat_m = 1'b1;
        else if (sat_clr) sat_m = 1'b0;
      end else if (sat_clr) begin
        sat_m = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  logic [19:0] held;
  logic [11:0] hist;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; pm_in = '0; out_ready = 1'b1; sat_clr = 1'b0;
    step(); step();
    chk("rst_out_valid", 32'(out_valid_a), 32'd0);
    chk("rst_pm_out", 32'(pm_out_a), 32'd0);
    chk("rst_sat_flag", 32'(sat_flag_a), 32'd0);
    chk("rst_in_ready", 32'(in_ready_a), 32'd1);
    rst_n = 1'b1;
    step();

    // Mode 0 single vector, exact 3-cycle latency.
    send(vec4(7, 3, 9, 3));
    step();
    chk("lat_not_early", 32'(out_valid_a), 32'd0);
    step();
    chk("t1_valid", 32'(out_valid_a), 32'd1);
    chk("t1_pm_out", 32'(pm_out_a), 32'(vec4(4, 0, 6, 0)));
    chk("t1_min_idx", 32'(min_idx_a), 32'd1);
    chk("t1_min_val", 32'(min_val_a), 32'd3);
    chk("t1_norm", 32'(normalized_a), 32'd1);
    chk("t1_b_pm_out", 32'(pm_out_b), 32'(vec4(7, 3, 9, 3)));
    chk("t1_b_norm", 32'(normalized_b), 32'd0);
    step(); step();

    // Mode 1 threshold: applied, then skipped.
    send(vec4(20, 18, 25, 30));
    send(vec4(10, 4, 12, 9));
    step();
    chk("t2a_pm_out", 32'(pm_out_b), 32'(vec4(2, 0, 7, 12)));
    chk("t2a_min_idx", 32'(min_idx_b), 32'd1);
    chk("t2a_norm", 32'(normalized_b), 32'd1);
    step();
    chk("t2b_pm_out", 32'(pm_out_b), 32'(vec4(10, 4, 12, 9)));
    chk("t2b_min_idx", 32'(min_idx_b), 32'd1);
    chk("t2b_min_val", 32'(min_val_b), 32'd4);
    chk("t2b_norm", 32'(normalized_b), 32'd0);
    step(); step();

    // Streaming 8 back-to-back vectors.
    for (int c = 0; c < 12; c++) begin
      in_valid = (c < 8);
      pm_in = vec4(c + 3, 2 * c, 9 - c, 3 * c);
      step();
      hist[c] = out_valid_a;
    end
    in_valid = 1'b0;
    chk("stream_pattern", 32'(hist), 32'(12'b0011_1111_1100));

    // Backpressure: stall with output held, then drain.
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1;
      pm_in = vec4(c + 1, c + 2, c + 3, c + 4);
      step();
    end
    pm_in = vec4(22, 17, 19, 16);
    chk("bp_in_ready", 32'(in_ready_a), 32'd0);
    chk("bp_out_valid", 32'(out_valid_a), 32'd1);
    chk("bp_first", 32'(pm_out_a), 32'(vec4(0, 1, 2, 3)));
    held = pm_out_a;
    for (int c = 0; c < 5; c++) begin
      step();
      chk("bp_hold_valid", 32'(out_valid_a), 32'd1);
      chk("bp_hold_pm", 32'(pm_out_a), 32'(held));
      chk("bp_hold_ready", 32'(in_ready_a), 32'd0);
    end
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (8) step();
    chk("bp_drain_a", 32'(qa.size()), 32'd0);
    chk("bp_drain_b", 32'(qb.size()), 32'd0);
    chk("bp_idle", 32'(out_valid_a), 32'd0);

    // Sticky saturation flag.
    send(vec4(31, 2, 5, 6));
    chk("sat_set", 32'(sat_flag_a), 32'd1);
    step(); step();
    chk("sat_sticky", 32'(sat_flag_a), 32'd1);
    sat_clr = 1'b1;
    step();
    sat_clr = 1'b0;
    chk("sat_cleared", 32'(sat_flag_a), 32'd0);
    sat_clr = 1'b1; in_valid = 1'b1; pm_in = vec4(3, 31, 0, 4);
    step();
    sat_clr = 1'b0; in_valid = 1'b0;
    chk("sat_set_wins", 32'(sat_flag_a), 32'd1);
    chk("sat_set_wins_b", 32'(sat_flag_b), 32'd1);
    repeat (5) step();

    // Reset with two vectors in flight discards both.
    send(vec4(5, 6, 7, 8));
    send(vec4(9, 1, 2, 3));
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mid_rst_valid", 32'(out_valid_a), 32'd0);
    chk("mid_rst_pm_out", 32'(pm_out_a), 32'd0);
    chk("mid_rst_min_idx", 32'(min_idx_a), 32'd0);
    chk("mid_rst_min_val", 32'(min_val_a), 32'd0);
    chk("mid_rst_norm", 32'(normalized_a), 32'd0);
    chk("mid_rst_sat", 32'(sat_flag_a), 32'd0);
    chk("mid_rst_b_valid", 32'(out_valid_b), 32'd0);
    for (int c = 0; c < 6; c++) begin
      step();
      chk("mid_rst_no_emit", 32'(out_valid_a | out_valid_b), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
